// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access/writeback stage with variable-latency data-memory handshake.
// Optional MISALIGN_CHECK_EN traps misaligned halfword/word accesses instead of issuing them.
module mem_wb_stage (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wb_sig,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_rs2_val,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] wb,
  output logic        wb_sig,
  output logic        stall,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] ex_a, a_q;
  logic [2:0] f3_q;
  logic load_q, wen_q, mis, mis_q, is_mem, accept;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, ld_data;
  logic [7:0] lb;
  logic [15:0] lh;
  assign ex_a = ex_alu[1:0];
  assign is_mem = ex_load | ex_store;
  assign accept = state != REQ;
  assign be_nx = ex_funct3[1:0] == 2'b00 ? 4'b0001 << ex_a :
                 ex_funct3[1:0] == 2'b01 ? 4'b0011 << {ex_a[1], 1'b0} : 4'hF;
  assign wdata_nx = ex_funct3[1:0] == 2'b00 ? {4{ex_rs2_val[7:0]}} :
                    ex_funct3[1:0] == 2'b01 ? {2{ex_rs2_val[15:0]}} : ex_rs2_val;
`ifdef MISALIGN_CHECK_EN
  assign mis = (ex_funct3[1:0] == 2'b01 && ex_a[0]) || (ex_funct3[1] && ex_a != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // load lane extraction uses the offset and size captured at accept time
  assign lb = dmem_rdata[{a_q, 3'b000} +: 8];
  assign lh = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign ld_data = f3_q == 3'b000 ? {{24{lb[7]}}, lb} :
                   f3_q == 3'b001 ? {{16{lh[15]}}, lh} :
                   f3_q == 3'b100 ? {24'b0, lb} :
                   f3_q == 3'b101 ? {16'b0, lh} : dmem_rdata;
  always_ff @(posedge cpu_clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = accept ? (!ex_valid ? IDLE : !is_mem ? RESP : mis ? IDLE : REQ) :
               dmem_ack ? (load_q ? RESP : IDLE) : REQ;
  always_comb begin
    stall = state == REQ;
    misalign = mis_q;
  end
  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      wb <= '0;
      wb_sig <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      mis_q <= 1'b0;
      a_q <= '0;
      f3_q <= '0;
      load_q <= 1'b0;
      wen_q <= 1'b0;
    end else if (accept) begin
      wb_sig <= ex_valid & ~is_mem & ex_wb_sig & |ex_rd;
      mis_q <= ex_valid & is_mem & mis;
      if (ex_valid && !is_mem) begin
        rd <= ex_rd;
        wb <= ex_alu;
      end
      if (ex_valid && is_mem && !mis) begin
        dmem_req <= 1'b1;
        dmem_we <= ex_store;
        dmem_addr <= {ex_alu[31:2], 2'b00};
        dmem_be <= be_nx;
        dmem_wdata <= wdata_nx;
        rd <= ex_rd;
        a_q <= ex_a;
        f3_q <= ex_funct3;
        load_q <= ex_load;
        wen_q <= ex_wb_sig & |ex_rd;
      end
    end else if (dmem_ack) begin
      dmem_req <= 1'b0;
      if (load_q) begin
        wb <= ld_data;
        wb_sig <= wen_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed test of mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;
  logic cpu_clk = 0, rst = 1, ex_valid = 0, ex_wb_sig = 0, ex_load = 0, ex_store = 0, dmem_ack = 0;
  logic [4:0] ex_rd = 0;
  logic [2:0] ex_funct3 = 0;
  logic [31:0] ex_alu = 0, ex_rs2_val = 0, dmem_rdata = 0;
  logic dmem_req, dmem_we, wb_sig, stall, misalign;
  logic [31:0] dmem_addr, dmem_wdata, wb;
  logic [3:0] dmem_be;
  logic [4:0] rd;
  int checks = 0, failures = 0, s;

  mem_wb_stage dut (
    .cpu_clk(cpu_clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wb_sig(ex_wb_sig),
    .ex_load(ex_load), .ex_store(ex_store), .ex_funct3(ex_funct3), .ex_alu(ex_alu),
    .ex_rs2_val(ex_rs2_val), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rd(rd), .wb(wb), .wb_sig(wb_sig), .stall(stall), .misalign(misalign)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model: 0 idle, 1 waiting on memory, 2 result presented
  int ms = 0, p_size = 4, p_lane = 0;
  logic e_req = 0, e_we = 0, e_wbsig = 0, e_mis = 0, p_load = 0, p_wen = 0, p_signed = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_wb = 0;
  logic [3:0] e_be = 0;
  logic [4:0] e_rd = 0;

  always @(posedge cpu_clk or posedge rst) begin : model
    int size, off, lane;
    logic [31:0] d, wd, m;
    if (rst) begin
      ms <= 0; e_req <= 0; e_we <= 0; e_wbsig <= 0; e_mis <= 0;
      e_addr <= 0; e_wdata <= 0; e_wb <= 0; e_be <= 0; e_rd <= 0;
    end else if (ms != 1) begin
      e_mis <= 0;
      if (!ex_valid) begin
        ms <= 0; e_wbsig <= 0;
      end else if (!ex_load && !ex_store) begin
        ms <= 2; e_rd <= ex_rd; e_wb <= ex_alu; e_wbsig <= ex_wb_sig && ex_rd != 0;
      end else begin
        size = ex_funct3[1:0] == 0 ? 1 : ex_funct3[1:0] == 1 ? 2 : 4;
        off = int'(ex_alu[1:0]);
        lane = (off / size) * size;
`ifdef MISALIGN_CHECK_EN
        if (off % size != 0) begin
          ms <= 0; e_mis <= 1; e_wbsig <= 0;
        end else
`endif
        begin
          for (int k = 0; k < 4; k++) wd[8*k +: 8] = ex_rs2_val[8*(k % size) +: 8];
          ms <= 1; e_req <= 1; e_we <= ex_store; e_addr <= ex_alu - 32'(off);
          e_be <= 4'(((1 << size) - 1) << lane); e_wdata <= wd; e_wbsig <= 0; e_rd <= ex_rd;
          p_load <= ex_load; p_wen <= ex_wb_sig && ex_rd != 0;
          p_size <= size; p_lane <= lane; p_signed <= !ex_funct3[2];
        end
      end
    end else if (dmem_ack) begin
      e_req <= 0;
      if (p_load) begin
        d = dmem_rdata >> (8 * p_lane);
        if (p_size < 4) begin
          m = (32'd1 << (8 * p_size)) - 1;
          d = d & m;
          if (p_signed && d[8*p_size-1]) d = d | ~m;
        end
        e_wb <= d; e_wbsig <= p_wen; ms <= 2;
      end else begin
        ms <= 0; e_wbsig <= 0;
      end
    end
  end

  always @(negedge cpu_clk) begin
    chk("stall", 32'(stall), 32'(ms == 1));
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("wb_sig", 32'(wb_sig), 32'(e_wbsig));
    chk("misalign", 32'(misalign), 32'(e_mis));
    chk("wb_sig_during_stall", 32'(wb_sig & stall), 0);
    if (e_req) begin
      chk("dmem_we", 32'(dmem_we), 32'(e_we));
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_be", 32'(dmem_be), 32'(e_be));
      chk("dmem_wdata", dmem_wdata, e_wdata);
    end
    if (e_wbsig) begin
      chk("rd", 32'(rd), 32'(e_rd));
      chk("wb", wb, e_wb);
    end
  end

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [4:0] r,
                       input logic w, input logic [31:0] alu, input logic [31:0] rs2);
    ex_valid = 1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_rd = r;
    ex_wb_sig = w; ex_alu = alu; ex_rs2_val = rs2;
    @(posedge cpu_clk); #1;
    ex_valid = 0; ex_load = 0; ex_store = 0;
  endtask

  task automatic ack_after(input int waits, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    for (int i = 0; i <= waits; i++) begin
      @(negedge cpu_clk);
      stalls += int'(stall);
      if (i == waits) begin
        dmem_ack = 1; dmem_rdata = rdata;
      end
    end
    @(posedge cpu_clk); #1;
    dmem_ack = 0;
  endtask

  initial begin
    #12;
    chk("rst_rd", 32'(rd), 0); chk("rst_wb", wb, 0); chk("rst_wb_sig", 32'(wb_sig), 0);
    chk("rst_req", 32'(dmem_req), 0); chk("rst_we", 32'(dmem_we), 0); chk("rst_addr", dmem_addr, 0);
    chk("rst_be", 32'(dmem_be), 0); chk("rst_wdata", dmem_wdata, 0); chk("rst_stall", 32'(stall), 0);
    chk("rst_misalign", 32'(misalign), 0);
    rst = 0;
    issue(0, 0, 3'b000, 5, 1, 32'h1234, 0);
    @(negedge cpu_clk);
    chk("add_rd", 32'(rd), 5); chk("add_wb", wb, 32'h1234); chk("add_wb_sig", 32'(wb_sig), 1);
    chk("add_stall", 32'(stall), 0);
    @(negedge cpu_clk);
    chk("add_wb_sig_drop", 32'(wb_sig), 0);
    issue(1, 0, 3'b000, 7, 1, 32'h103, 0);
    chk("lb_addr", dmem_addr, 32'h100); chk("lb_be", 32'(dmem_be), 4'b1000); chk("lb_req", 32'(dmem_req), 1);
    ack_after(3, 32'h80FF_FF7F, s);
    chk("lb_stall_cycles", 32'(s), 4);
    @(negedge cpu_clk);
    chk("lb_wb", wb, 32'hFFFF_FF80); chk("lb_wb_sig", 32'(wb_sig), 1); chk("lb_rd", 32'(rd), 7);
    chk("lb_stall_after", 32'(stall), 0);
    issue(1, 0, 3'b101, 8, 1, 32'h102, 0);
    ack_after(0, 32'hBEEF_0000, s);
    @(negedge cpu_clk);
    chk("lhu_wb", wb, 32'h0000_BEEF); chk("lhu_stall_cycles", 32'(s), 1);
    issue(0, 1, 3'b001, 9, 0, 32'h102, 32'h1234_ABCD);
    chk("sh_be", 32'(dmem_be), 4'b1100); chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dmem_we), 1);
    ack_after(1, 0, s);
    @(negedge cpu_clk);
    chk("sh_wb_sig", 32'(wb_sig), 0);
    issue(0, 1, 3'b000, 0, 0, 32'h001, 32'h0000_00AB);
    chk("sb_be", 32'(dmem_be), 4'b0010); chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    ack_after(0, 0, s);
    issue(1, 0, 3'b001, 3, 1, 32'h002, 0);
    ack_after(2, 32'h8001_1234, s);
    @(negedge cpu_clk);
    chk("lh_wb", wb, 32'hFFFF_8001);
    issue(1, 0, 3'b010, 0, 1, 32'h40, 0);
    chk("ld_x0_req", 32'(dmem_req), 1);
    ack_after(0, 32'hDEAD_BEEF, s);
    @(negedge cpu_clk);
    chk("ld_x0_wb_sig", 32'(wb_sig), 0);
    issue(1, 0, 3'b011, 4, 1, 32'h48, 0);
    chk("f3_011_be", 32'(dmem_be), 4'hF);
    ack_after(0, 32'hCAFE_F00D, s);
    @(negedge cpu_clk);
    chk("f3_011_wb", wb, 32'hCAFE_F00D);
    issue(0, 0, 3'b000, 1, 1, 32'h11, 0);
    issue(0, 0, 3'b000, 2, 1, 32'h22, 0);
    chk("b2b_rd", 32'(rd), 2); chk("b2b_wb", wb, 32'h22); chk("b2b_wb_sig", 32'(wb_sig), 1);
    issue(0, 0, 3'b000, 0, 1, 32'h33, 0);
    chk("x0_alu_wb_sig", 32'(wb_sig), 0);
    @(negedge cpu_clk);
    dmem_ack = 1; dmem_rdata = 32'h5555_5555;
    @(negedge cpu_clk);
    dmem_ack = 0;
    chk("idle_ack_stall", 32'(stall), 0); chk("idle_ack_req", 32'(dmem_req), 0);
    issue(1, 0, 3'b010, 6, 1, 32'h80, 0);
    @(negedge cpu_clk);
    chk("rst_mid_req_before", 32'(dmem_req), 1);
    #2 rst = 1;
    #1 chk("rst_mid_req_req", 32'(dmem_req), 0); chk("rst_mid_req_stall", 32'(stall), 0);
    #1 rst = 0;
    @(negedge cpu_clk);
    chk("rst_mid_req_wb_sig", 32'(wb_sig), 0);
    @(negedge cpu_clk);
    chk("rst_mid_req_wb_sig2", 32'(wb_sig), 0);
    issue(1, 0, 3'b010, 10, 1, 32'h101, 0);
`ifdef MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign), 1); chk("mis_req", 32'(dmem_req), 0); chk("mis_wb_sig", 32'(wb_sig), 0);
    @(posedge cpu_clk); #1;
    chk("mis_drop", 32'(misalign), 0); chk("mis_req2", 32'(dmem_req), 0); chk("mis_wb_sig2", 32'(wb_sig), 0);
`else
    chk("mis_off_req", 32'(dmem_req), 1); chk("mis_off_be", 32'(dmem_be), 4'hF);
    chk("mis_off_addr", dmem_addr, 32'h100); chk("mis_off_flag", 32'(misalign), 0);
    ack_after(0, 32'h0102_0304, s);
    @(negedge cpu_clk);
    chk("mis_off_wb", wb, 32'h0102_0304);
`endif
    repeat (3) @(negedge cpu_clk);
    #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the RISC-V pipeline, sitting directly upstream of the register file. It captures one executed instruction per accepted cycle and issues a data-memory request for loads and stores. It waits on a handshake of variable latency, aligns and extends load data, and presents the registered `rd`/`wb`/`wb_sig` triple the register file consumes. While a memory access is outstanding it holds `stall` high to freeze the upstream pipeline and the register-file write.

## Interface
- No parameters.
- `cpu_clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: an instruction is present from EX.
- `ex_rd` in 5: destination register.
- `ex_wb_sig` in 1: the instruction writes `rd`.
- `ex_load` in 1: load instruction.
- `ex_store` in 1: store instruction.
- `ex_funct3` in 3: access size/sign.
- `ex_alu` in 32: ALU result, or effective address for memory ops.
- `ex_rs2_val` in 32: store data.
- `dmem_req` out 1: memory request, held until ack.
- `dmem_we` out 1: 1 means store.
- `dmem_addr` out 32: word address, with `[1:0]` = 0.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: request completes this cycle; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 32: load word.
- `rd` out 5: writeback register index (registered).
- `wb` out 32: writeback data (registered).
- `wb_sig` out 1: writeback enable, a one-cycle pulse per instruction.
- `stall` out 1: upstream must hold its outputs.
- `misalign` out 1: one-cycle pulse on a misaligned access.

## Operation
- States are IDLE, REQ and RESP.
- `stall` = (state == REQ). The stage accepts `ex_*` on a rising edge only when `stall` = 0.
- IDLE/RESP accepting `ex_valid`=1 with neither load nor store: next state RESP.
  - `rd`=`ex_rd`, `wb`=`ex_alu`.
  - `wb_sig` = `ex_wb_sig` && `ex_rd`≠0.
- Accepting a load or store: next state REQ.
  - Drive `dmem_req`=1, `dmem_we`=`ex_store`, `dmem_addr`={`ex_alu[31:2]`,2'b00}.
  - `wb_sig`=0 while in REQ.
- Accepting `ex_valid`=0: next state IDLE, `wb_sig`=0.
- REQ with `dmem_ack`=0: all `dmem_*` outputs stay stable.
- REQ with `dmem_ack`=1: drop `dmem_req`.
  - Load: next state RESP, with `wb` = extended data and `wb_sig` = (`ex_wb_sig`&&`rd`≠0) as captured.
  - Store: next state IDLE, `wb_sig`=0.
- Store lanes, with `a` = `ex_alu[1:0]`:
  - SB (000): `be`=4'b0001<<a, `wdata`={4{rs2[7:0]}}.
  - SH (001): `be`=4'b0011<<{a[1],0}, `wdata`={2{rs2[15:0]}}.
  - SW: `be`=4'hF, `wdata`=rs2.
- Load extraction uses the same lane selection.
  - LB=000 and LH=001 sign-extend.
  - LBU=100 and LHU=101 zero-extend.
  - LW=010. Codes 011, 110 and 111 are treated as LW.
  - Loads drive `dmem_be` the same as stores of the same size.
- `dmem_ack` outside REQ is ignored.
- Reset values: state IDLE; `rd`=0, `wb`=0, `wb_sig`=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_be`=0, `dmem_wdata`=0, `stall`=0, `misalign`=0.
- Reset asserted mid-REQ: `dmem_req` drops immediately (asynchronous). The pending access is discarded and no writeback occurs.

## Timing
- Non-memory op accepted at edge N: `wb_sig`/`rd`/`wb` are valid during cycle N+1. The register file writes at the end of N+1.
- Load/store accepted at edge N: `dmem_req`=1 and `stall`=1 from cycle N+1.
- Ack in cycle M (M ≥ N+1):
  - `stall`=0 from cycle M+1.
  - Load `wb_sig` is valid in cycle M+1.
  - A new instruction is accepted at the end of M+1.
- Zero-wait memory gives 2-cycle load latency and 1 memory op per 2 cycles.
- `wb_sig` is never high while `stall`=1.

## Configuration
- `MISALIGN_CHECK_EN` defined:
  - Triggers on an LH/LHU/SH access with `a[0]`=1, or a word access with `a`≠0.
  - Transitions to IDLE instead of REQ, with no `dmem_req` and no writeback.
  - Pulses `misalign`=1 for cycle N+1.
- Not defined:
  - `misalign` is tied to 0.
  - Misaligned accesses proceed with the lane rules above (the low address bit is ignored for halfwords, both low bits for words).

## Test plan
- ADD-like op `ex_rd`=5, `ex_alu`=32'h1234, `ex_wb_sig`=1 → next cycle `rd`=5, `wb`=32'h1234, `wb_sig`=1 and `stall`=0. The cycle after, `wb_sig`=0.
- LB at 0x103 with 3 wait cycles and `dmem_rdata`=32'h80FF_FF7F → `dmem_addr`=0x100, `be`=4'b1000, `stall`=1 for 4 cycles. Then `wb`=32'hFFFF_FF80.
- LHU at 0x102 with `rdata`=32'hBEEF_0000 → `wb`=32'h0000_BEEF. SH at 0x102 with rs2=32'h1234_ABCD → `be`=4'b1100, `wdata`=32'hABCD_ABCD, `we`=1, and no `wb_sig`.
- Load with `ex_rd`=0 → memory access happens and `wb_sig` stays 0. `rst` pulsed mid-REQ → `dmem_req` and `stall` fall without a clock edge, and no writeback follows.
- With `MISALIGN_CHECK_EN`: LW at 0x101 → `misalign` pulses for 1 cycle, with `dmem_req`=0 and `wb_sig`=0 throughout.
- `dmem_ack` pulsed while IDLE → no state change.
